// File: rtl/perf_counter_bank.sv
// Bank of CHANNELS event counters with wrap/saturate, sticky overflow and a registered CSR read port.
// Optional overflow interrupt with per-channel mask: define PERF_COUNTER_BANK_IRQ_EN.

module perf_counter_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             freeze,
  input  logic             cnt_we,
  input  logic             ctl_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
`ifdef PERF_COUNTER_BANK_IRQ_EN
  ,
  output logic             irq_req
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             count;
  logic             all_ones;

  assign count    = evt & en_q & ~freeze;
  assign all_ones = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    en_d  = en_q;
    sat_d = sat_q;
    // clear first so a same-cycle overflow set wins
    if (ovf_clr) ovf_d = 1'b0;
    if (cnt_we) begin
      cnt_d = wr_data;
    end else if (count) begin
      if (!all_ones) begin
        cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        ovf_d = 1'b1;
        if (!sat_q) cnt_d = '0;
      end
    end
    if (ctl_we) begin
      en_d  = wr_data[0];
      sat_d = wr_data[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

`ifdef PERF_COUNTER_BANK_IRQ_EN
  logic mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (ctl_we) mask_d = wr_data[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= 1'b0;
    else     mask_q <= mask_d;
  end

  assign irq_req = ovf_q & mask_q;
`endif

endmodule

module perf_counter_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] evt,
  input  logic                freeze,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cnt_we,
  input  logic                ctl_we,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] ovf,
  input  logic [CHANNELS-1:0] ovf_clr,
  output logic                irq
);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt;
  logic [CHANNELS-1:0]            sel_hit;
`ifdef PERF_COUNTER_BANK_IRQ_EN
  logic [CHANNELS-1:0]            irq_req;
`endif

  // out-of-range selects hit no channel, so writes drop and reads mux to 0
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign sel_hit[g] = (sel == SEL_W'(g));

    perf_counter_chan #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .evt     (evt[g]),
      .freeze  (freeze),
      .cnt_we  (cnt_we & sel_hit[g]),
      .ctl_we  (ctl_we & sel_hit[g]),
      .wr_data (wr_data),
      .ovf_clr (ovf_clr[g]),
      .cnt     (cnt[g]),
      .ovf     (ovf[g])
`ifdef PERF_COUNTER_BANK_IRQ_EN
      ,
      .irq_req (irq_req[g])
`endif
    );
  end

  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel_hit[i]) rd_mux = cnt[i];
    rd_data_d  = rd_en ? rd_mux : rd_data_q;
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef PERF_COUNTER_BANK_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = |irq_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: counting, wrap/saturate, ovf, write/read ordering, freeze, reset, sel range, irq.

module tb_perf_counter_bank;

`ifdef PERF_COUNTER_BANK_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  evt;
  logic        freeze;
  logic [1:0]  sel;
  logic        cnt_we, ctl_we, rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  ovf, ovf_clr;
  logic        irq;

  // second instance with a non-power-of-two channel count
  logic [4:0]  evt5, ovf5, ovf_clr5;
  logic [2:0]  sel5;
  logic        cnt_we5, ctl_we5, rd_en5;
  logic [31:0] rd_data5;
  logic        rd_valid5, irq5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .evt(evt), .freeze(freeze), .sel(sel),
    .cnt_we(cnt_we), .ctl_we(ctl_we), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .ovf(ovf), .ovf_clr(ovf_clr), .irq(irq)
  );

  perf_counter_bank #(.WIDTH(32), .CHANNELS(5), .SEL_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .evt(evt5), .freeze(1'b0), .sel(sel5),
    .cnt_we(cnt_we5), .ctl_we(ctl_we5), .wr_data(wr_data), .rd_en(rd_en5),
    .rd_data(rd_data5), .rd_valid(rd_valid5), .ovf(ovf5), .ovf_clr(ovf_clr5), .irq(irq5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // all helpers start and end just after a falling edge
  task automatic wr_ctl(input logic [1:0] ch, input logic [31:0] v);
    sel = ch; ctl_we = 1'b1; wr_data = v;
    @(negedge clk);
    ctl_we = 1'b0;
  endtask

  task automatic wr_cnt(input logic [1:0] ch, input logic [31:0] v);
    sel = ch; cnt_we = 1'b1; wr_data = v;
    @(negedge clk);
    cnt_we = 1'b0;
  endtask

  task automatic events(input logic [3:0] m, input int n);
    evt = m;
    repeat (n) @(negedge clk);
    evt = '0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [31:0] exp, input string tag);
    sel = ch; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic rd5(input logic [2:0] ch, input logic [31:0] exp, input string tag);
    sel5 = ch; rd_en5 = 1'b1;
    @(negedge clk);
    rd_en5 = 1'b0;
    chk({tag, "_vld"}, {31'b0, rd_valid5}, 32'd1);
    chk(tag, rd_data5, exp);
  endtask

  initial begin
    rst = 1'b1; evt = '0; freeze = 1'b0; sel = '0; cnt_we = 1'b0; ctl_we = 1'b0;
    rd_en = 1'b0; wr_data = '0; ovf_clr = '0;
    evt5 = '0; ovf_clr5 = '0; sel5 = '0; cnt_we5 = 1'b0; ctl_we5 = 1'b0; rd_en5 = 1'b0;
    #12;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_ovf", {28'b0, ovf}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // disabled after reset
    events(4'b1111, 10);
    rd(2'd0, 32'd0, "dis_c0");
    rd(2'd3, 32'd0, "dis_c3");
    wr_ctl(2'd0, 32'h1);
    events(4'b1111, 10);
    rd(2'd0, 32'd10, "en_c0");
    rd(2'd1, 32'd0, "en_c1");

    // wrap with overflow, then clear
    wr_ctl(2'd1, 32'h1);
    wr_cnt(2'd1, 32'hFFFF_FFFE);
    events(4'b0010, 3);
    chk("wrap_ovf", {28'b0, ovf}, 32'h2);
    chk("wrap_irq", {31'b0, irq}, 32'd0);
    rd(2'd1, 32'd1, "wrap_c1");
    ovf_clr = 4'b0010;
    @(negedge clk);
    ovf_clr = '0;
    chk("clr_ovf", {28'b0, ovf}, 32'h0);

    // saturate; set beats clear in the same cycle
    wr_ctl(2'd2, 32'h3);
    wr_cnt(2'd2, 32'hFFFF_FFFF);
    events(4'b0100, 5);
    chk("sat_ovf", {28'b0, ovf}, 32'h4);
    rd(2'd2, 32'hFFFF_FFFF, "sat_c2");
    evt = 4'b0100; ovf_clr = 4'b0100;
    @(negedge clk);
    evt = '0; ovf_clr = '0;
    chk("setclr_ovf", {28'b0, ovf}, 32'h4);

    // write beats event; same-cycle read returns old value
    wr_ctl(2'd3, 32'h1);
    events(4'b1000, 7);
    sel = 2'd3; cnt_we = 1'b1; wr_data = 32'd100; evt = 4'b1000; rd_en = 1'b1;
    @(negedge clk);
    cnt_we = 1'b0; evt = '0; rd_en = 1'b0;
    chk("wrrd_vld", {31'b0, rd_valid}, 32'd1);
    chk("wrrd_old", rd_data, 32'd7);
    @(negedge clk);
    chk("rd_vld_drop", {31'b0, rd_valid}, 32'd0);
    chk("rd_hold", rd_data, 32'd7);
    rd(2'd3, 32'd100, "wr_c3");
    freeze = 1'b1;
    events(4'b1000, 8);
    freeze = 1'b0;
    rd(2'd3, 32'd100, "frz_c3");

    // back-to-back reads
    sel = 2'd0; rd_en = 1'b1;
    @(negedge clk);
    chk("b2b0", rd_data, 32'd10);
    sel = 2'd1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("b2b1_vld", {31'b0, rd_valid}, 32'd1);
    chk("b2b1", rd_data, 32'd1);

    // asynchronous reset mid-cycle with a read in flight
    evt = 4'b0001; sel = 2'd0; rd_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ovf", {28'b0, ovf}, 32'h0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_rd_valid", {31'b0, rd_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; evt = '0; rd_en = 1'b0;
    events(4'b0001, 3);
    rd(2'd0, 32'd0, "arst_c0");
    rd(2'd2, 32'd0, "arst_c2");

    // out-of-range select on the 5-channel instance
    sel5 = 3'd4; cnt_we5 = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    cnt_we5 = 1'b0;
    rd5(3'd4, 32'h1234, "oob_c4");
    sel5 = 3'd5; cnt_we5 = 1'b1; ctl_we5 = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    cnt_we5 = 1'b0; ctl_we5 = 1'b0;
    rd5(3'd5, 32'd0, "oob_rd");
    rd5(3'd1, 32'd0, "oob_c1");
    rd5(3'd4, 32'h1234, "oob_c4b");

    // interrupt path; bit 2 is the mask when the feature is built in
    wr_ctl(2'd1, 32'h5);
    wr_cnt(2'd1, 32'hFFFF_FFFF);
    evt = 4'b0010;
    @(negedge clk);
    evt = '0;
    chk("irq_ovf", {28'b0, ovf}, 32'h2);
    chk("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'b0, irq}, {31'b0, IRQ});
    ovf_clr = 4'b0010;
    @(negedge clk);
    ovf_clr = '0;
    chk("irq_clr_ovf", {28'b0, ovf}, 32'h0);
    chk("irq_hold", {31'b0, irq}, {31'b0, IRQ});
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
